// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter giving the renderer absolute priority,
// with a posted CPU write FIFO and a stalling CPU read path.
module vram_arbiter #(
    parameter int FIFO_AW = 2,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              vid_busy,
    output logic [15:0]       vid_read,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [15:0]       cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic {IDLE, READ} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   f_addr [DEPTH];
    logic [15:0]         f_data [DEPTH];
    logic [FIFO_AW-1:0]  rd_ptr, wr_ptr;
    logic [FIFO_AW:0]    count;
    logic [ADDR_W-1:0]   rd_addr;
    logic                push, pop, rd_acc, rd_done;

    assign vid_read = mem_rdata;

    always_comb begin
        pop       = !vid_busy && state == IDLE && count != '0;
        rd_done   = state == READ && !vid_busy;
        cpu_ready = cpu_we ? (count != (FIFO_AW+1)'(DEPTH))
                           : (state == IDLE && count == '0 && !vid_busy && !cpu_rvalid);
        push      = cpu_req && cpu_we && cpu_ready;
        rd_acc    = cpu_req && !cpu_we && cpu_ready;
        mem_addr  = vid_busy ? vid_addr : pop ? f_addr[rd_ptr] : rd_addr;
        mem_we    = pop;
        mem_wdata = f_data[rd_ptr];
        state_nx  = rd_acc ? READ : rd_done ? IDLE : state;
    end

    // FIFO storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            f_addr[wr_ptr] <= cpu_addr;
            f_data[wr_ptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rd_addr    <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            state      <= state_nx;
            cpu_rvalid <= rd_done;
            count      <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            if (push)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            if (rd_acc)
                rd_addr <= cpu_addr;
            if (rd_done)
                cpu_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized and directed checks of vram_arbiter against a
// queue-based transaction model with its own shadow memory.
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] vid_addr = '0;
    logic        vid_busy = 1'b0;
    logic [15:0] vid_read;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ready, cpu_rvalid;
    logic [15:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    always #5 clk = ~clk;

    vram_arbiter #(.FIFO_AW(2), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .vid_addr(vid_addr), .vid_busy(vid_busy),
        .vid_read(vid_read), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [15:0] ram [0:65535];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    logic [15:0] m_mem [0:65535];
    bit   [15:0] q_a[$], q_d[$];
    bit          m_rd, m_rv;
    bit   [15:0] m_ra, m_rdata;
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void mdl_reset();
        q_a.delete();
        q_d.delete();
        m_rd = 0;
        m_rv = 0;
        m_ra = '0;
        m_rdata = '0;
    endfunction

    task automatic poke(input bit [15:0] a, input bit [15:0] d);
        ram[a] = d;
        m_mem[a] = d;
    endtask

    // One clock cycle: drive, check every output against the model, advance the model.
    task automatic step(input bit busy, input bit req, input bit we,
                        input bit [15:0] a, input bit [15:0] d, input bit [15:0] va);
        bit        e_rdy, drain;
        bit [15:0] e_addr;
        @(negedge clk);
        vid_busy = busy; cpu_req = req; cpu_we = we;
        cpu_addr = a; cpu_wdata = d; vid_addr = va;
        #1;
        e_rdy  = we ? (q_a.size() != 4) : (!m_rd && q_a.size() == 0 && !busy && !m_rv);
        drain  = !busy && !m_rd && q_a.size() != 0;
        e_addr = busy ? va : drain ? q_a[0] : m_ra;
        chk("cpu_ready", 32'(cpu_ready), 32'(e_rdy));
        chk("mem_we", 32'(mem_we), 32'(drain));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (drain) chk("mem_wdata", 32'(mem_wdata), 32'(q_d[0]));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rv));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
        chk("vid_read", 32'(vid_read), 32'(m_mem[e_addr]));
        m_rv = m_rd && !busy;
        if (m_rv) begin
            m_rdata = m_mem[m_ra];
            m_rd = 0;
        end
        if (drain) begin
            m_mem[q_a[0]] = q_d[0];
            void'(q_a.pop_front());
            void'(q_d.pop_front());
        end
        if (req && e_rdy) begin
            if (we) begin
                q_a.push_back(a);
                q_d.push_back(d);
            end else begin
                m_rd = 1;
                m_ra = a;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        int burst;
        bit busy_lvl;
        for (int i = 0; i < 65536; i++) begin
            ram[i]   = 16'(i * 7 + 3);
            m_mem[i] = 16'(i * 7 + 3);
        end
        mdl_reset();
        #3;
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("rst_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // posted write then read
        step(0, 1, 1, 16'h0040, 16'hBEEF, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0, 16'h0);
        step(0, 1, 0, 16'h0040, 16'h0, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0, 16'h0);
        chk("rd_beef", 32'(cpu_rdata), 32'hBEEF);

        // FIFO fill under busy, then video passthrough with FIFO non-empty
        poke(16'h7E05, 16'h1234);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 16'(16'h10 + i), 16'(16'hA0 + i), 16'h0);
        step(1, 0, 0, 16'h0, 16'h0, 16'h7E05);
        chk("vid_pass", 32'(vid_read), 32'h1234);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 16'h0014, 16'h00A4, 16'h0);
        idle(3);

        // read interrupted by busy
        step(0, 1, 0, 16'h0100, 16'h0, 16'h0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 16'h0, 16'h0, 16'(16'h3000 + i));
        idle(3);

        // read/write ordering
        poke(16'h0200, 16'h0001);
        step(0, 1, 0, 16'h0200, 16'h0, 16'h0);
        step(0, 1, 1, 16'h0200, 16'h0002, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0, 16'h0);
        chk("ord_old", 32'(cpu_rdata), 32'h0001);
        idle(2);
        step(0, 1, 0, 16'h0200, 16'h0, 16'h0);
        idle(2);
        chk("ord_new", 32'(cpu_rdata), 32'h0002);

        // async reset mid-drain
        for (int i = 0; i < 4; i++) step(1, 1, 1, 16'(16'h50 + i), 16'(16'hC0 + i), 16'h0);
        step(0, 0, 0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        vid_busy = 0; cpu_req = 0; cpu_we = 1;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_mem_we", 32'(mem_we), 32'h0);
        chk("arst_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("arst_ready_w", 32'(cpu_ready), 32'h1);
        mdl_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        cpu_we = 0;
        #1;
        chk("arst_ready_r", 32'(cpu_ready), 32'h1);
        idle(3);

        // randomized traffic with busy bursts
        burst = 0;
        busy_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if (burst == 0) begin
                burst = $urandom_range(1, 12);
                busy_lvl = ($urandom_range(0, 2) == 0);
            end
            burst--;
            step(busy_lvl, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 16'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sits directly upstream of the tile renderer and owns the single-port 16-bit video RAM.
- Arbitrates between two clients:
  - the renderer, which has absolute priority whenever it asserts its busy flag;
  - the CPU, which gets a posted-write FIFO plus a stalling read path.
- Guarantees the renderer combinational RAM access during its row fetch window, then drains buffered CPU writes in order.

Parameters:
- FIFO_AW, 2, log2 of the CPU write FIFO depth (default depth 4).
- ADDR_W, 16, RAM address width.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-low
- vid_addr  input  ADDR_W  renderer RAM address
- vid_busy  input  1  renderer owns RAM while high
- vid_read  output  16  RAM read data to renderer
- cpu_req  input  1  CPU request valid
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_W  CPU address
- cpu_wdata  input  16  CPU write data
- cpu_ready  output  1  request accepted this cycle when cpu_req && cpu_ready
- cpu_rvalid  output  1  one-cycle pulse, cpu_rdata valid
- cpu_rdata  output  16  CPU read data
- mem_addr  output  ADDR_W  RAM address (RAM read is combinational, write is synchronous)
- mem_we  output  1  RAM write enable
- mem_wdata  output  16  RAM write data
- mem_rdata  input  16  RAM read data

Behaviour:
- **Reset (reset low, asynchronous):**
  - FIFO empty (rd_ptr = wr_ptr = count = 0); state IDLE.
  - cpu_rvalid = 0, cpu_rdata = 0, read address register = 0.
  - mem_we = 0.
- **vid_read:** always equals mem_rdata, combinational.
- **Video priority (vid_busy = 1):**
  - mem_addr = vid_addr, combinational with zero added latency.
  - mem_we = 0; no FIFO pop.
  - The renderer's registered address is therefore read back in the following cycle.
- **State machine, states IDLE and READ:**
  - IDLE, vid_busy = 0, FIFO non-empty:
    - mem_addr / mem_wdata = FIFO head, mem_we = 1.
    - Pop at the clock edge; one write per cycle; FIFO order preserved.
  - IDLE, FIFO empty, vid_busy = 0:
    - mem_addr = registered read address (don't-care); mem_we = 0.
  - IDLE -> READ: on an accepted read; cpu_addr is latched into the read address register.
  - READ, vid_busy = 0:
    - mem_addr = read address, mem_we = 0.
    - At the edge, cpu_rdata <= mem_rdata, cpu_rvalid <= 1 for exactly one cycle, state -> IDLE.
    - Read latency from the accept edge is 2 cycles (rvalid high in cycle t+2).
  - READ, vid_busy = 1: state holds and the read retries every cycle until vid_busy = 0; cpu_rvalid stays 0.
- **cpu_ready rules:**
  - Write: cpu_ready = (count != 2^FIFO_AW). Write acceptance is independent of vid_busy and state.
  - Read: cpu_ready = state IDLE && count == 0 && !vid_busy && !cpu_rvalid.
  - cpu_ready depends on cpu_we, combinationally.
- **Push:**
  - On cpu_req && cpu_we && cpu_ready, {cpu_addr, cpu_wdata} is written at wr_ptr; wr_ptr increments and wraps modulo depth.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push when full is impossible because ready = 0; a pop that same cycle does not make ready high (no combinational full bypass).
- **Ordering:**
  - A read is only accepted with the FIFO empty, so it observes all earlier writes.
  - Writes accepted while in READ are not drained until READ completes, so the read never sees later writes.
- **Counters:**
  - count is FIFO_AW+1 bits and saturation-free by construction.
  - Pointers are FIFO_AW bits and wrap naturally.
- **vid_busy rising mid-drain:** the drain pauses immediately in that cycle (mem_we = 0) and resumes when vid_busy falls; no entry is lost or duplicated.
- **Reset mid-operation:** pending FIFO entries and any in-flight read are discarded; no rvalid is issued.

Test Plan:
- **Posted write then read:**
  - Write 0x0040 <- 0xBEEF with vid_busy = 0.
  - Required: mem_we = 1 with mem_addr 0x0040 in the cycle after accept.
  - Read 0x0040 accepted at t; cpu_rvalid = 1 at t+2 with cpu_rdata = 0xBEEF.
- **FIFO fill under video busy:**
  - Hold vid_busy = 1; issue 5 writes to 0x10..0x14.
  - Required: first 4 accepted, 5th sees cpu_ready = 0; mem_we stays 0.
  - Drop vid_busy: 4 consecutive mem_we cycles at 0x10..0x13, then the 5th write is accepted and drained.
- **Video passthrough:**
  - vid_busy = 1, vid_addr = 0x7E05, RAM[0x7E05] = 0x1234.
  - Required: mem_addr = 0x7E05 and vid_read = 0x1234 in the same cycle, with the FIFO non-empty.
- **Read interrupted by busy:**
  - Accept read of 0x0100; assert vid_busy for 10 cycles starting t+1.
  - Required: cpu_rvalid = 0 throughout; rvalid pulses exactly once, 1 cycle after vid_busy falls, with the correct data.
- **Read/write ordering:**
  - Accept read of 0x0200 (RAM = 0x0001); while in READ, push write 0x0200 <- 0x0002.
  - Required: cpu_rdata = 0x0001, then the write drains; a subsequent read returns 0x0002.
- **Async reset:**
  - Assert reset low mid-drain with 3 entries queued.
  - Required: mem_we = 0 and cpu_rvalid = 0 immediately, without a clock; after release, count = 0, cpu_ready = 1 for both reads and writes, and no stale writes appear.
